// File: rtl/alu_ctrl_pkg.sv
// Shared constants, decode payload and occupancy encoding for the ALU-control stage.
package alu_ctrl_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned FUNCT_W = 4;

  localparam logic [OP_W-1:0] OP_AND     = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR      = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD     = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB     = 4'b0110;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 4'b1111;

  localparam logic [ALUOP_W-1:0] ALUOP_MEM = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BR  = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_R   = 2'b10;

  localparam logic [FUNCT_W-1:0] F_ADD = 4'b0000;
  localparam logic [FUNCT_W-1:0] F_SUB = 4'b1000;
  localparam logic [FUNCT_W-1:0] F_AND = 4'b0111;
  localparam logic [FUNCT_W-1:0] F_OR  = 4'b0110;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } occ_state_e;

  typedef struct packed {
    logic [OP_W-1:0] operation;
    logic            illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// Decode-side and execute-side handshake bundle of the ALU-control stage.
interface alu_ctrl_stage_if #(
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_alu_op;
  logic [3:0]       in_funct;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_operation;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  // Upstream decode and downstream execute as seen together from outside the stage.
  modport master (
    output in_valid, in_alu_op, in_funct, in_tag, out_ready,
    input  in_ready, out_valid, out_operation, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_alu_op, in_funct, in_tag, out_ready,
    output in_ready, out_valid, out_operation, out_tag, out_illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational (ALUOp, funct) to ALU operation decoder; unknown pairs flag illegal.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [ALUOP_W-1:0] i_alu_op,
  input  logic [FUNCT_W-1:0] i_funct,
  output dec_t               o_dec_c
);

  always_comb begin
    o_dec_c = '{operation: OP_ILLEGAL, illegal: 1'b1};
    case (i_alu_op)
      ALUOP_MEM: o_dec_c = '{operation: OP_ADD, illegal: 1'b0};
      ALUOP_BR:  o_dec_c = '{operation: OP_SUB, illegal: 1'b0};
      ALUOP_R: begin
        case (i_funct)
          F_ADD:   o_dec_c = '{operation: OP_ADD, illegal: 1'b0};
          F_SUB:   o_dec_c = '{operation: OP_SUB, illegal: 1'b0};
          F_AND:   o_dec_c = '{operation: OP_AND, illegal: 1'b0};
          F_OR:    o_dec_c = '{operation: OP_OR,  illegal: 1'b0};
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control stage: decode, 2-entry main/skid buffer, flush,
// sticky illegal flag and output-transfer counter.
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_ctrl_stage_if.slave  bus,
  input  logic             flush,
  input  logic             illegal_clr,
  output logic             illegal_sticky,
  output logic [CNT_W-1:0] issue_count
);

  occ_state_e       r_state;
  occ_state_e       w_next;
  logic             r_out_valid;
  logic             r_in_ready;
  dec_t             r_main_dec;
  logic [TAG_W-1:0] r_main_tag;
  dec_t             r_skid_dec;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_sticky;
  logic [CNT_W-1:0] r_count;

  dec_t w_dec;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;

  alu_op_decode u_decode (
    .i_alu_op (bus.in_alu_op),
    .i_funct  (bus.in_funct),
    .o_dec_c  (w_dec)
  );

  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & bus.out_ready;

  // Occupancy next-state and entry load selects; flush overrides everything.
  always_comb begin
    w_next         = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_next       = ST_FULL;
            w_ld_main_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_in_xfer && w_out_xfer) begin
            w_ld_main_in = 1'b1;
          end else if (w_in_xfer) begin
            w_next    = ST_SKID;
            w_ld_skid = 1'b1;
          end else if (w_out_xfer) begin
            w_next = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_out_xfer) begin
            w_next         = ST_FULL;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_out_valid <= (w_next != ST_EMPTY);
      r_in_ready  <= (w_next != ST_SKID);
    end
  end

  // Main entry drives the outputs and only changes on a load, so it holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_dec <= '0;
      r_main_tag <= '0;
      r_skid_dec <= '0;
      r_skid_tag <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main_dec <= w_dec;
        r_main_tag <= bus.in_tag;
      end else if (w_ld_main_skid) begin
        r_main_dec <= r_skid_dec;
        r_main_tag <= r_skid_tag;
      end
      if (w_ld_skid) begin
        r_skid_dec <= w_dec;
        r_skid_tag <= bus.in_tag;
      end
    end
  end

  // A dropped (flushed) input is never accepted, so it cannot raise the sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_in_xfer && !flush && w_dec.illegal) begin
        r_sticky <= 1'b1;
      end else if (illegal_clr) begin
        r_sticky <= 1'b0;
      end
      if (w_out_xfer) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_operation = r_main_dec.operation;
  assign bus.out_illegal   = r_main_dec.illegal;
  assign bus.out_tag       = r_main_tag;
  assign illegal_sticky    = r_sticky;
  assign issue_count       = r_count;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: decode table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_alu_ctrl_stage;

  localparam int unsigned TAG_W = 5;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             illegal_clr;
  logic             illegal_sticky;
  logic [CNT_W-1:0] issue_count;

  alu_ctrl_stage_if #(.TAG_W(TAG_W)) bus ();

  alu_ctrl_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .flush          (flush),
    .illegal_clr    (illegal_clr),
    .illegal_sticky (illegal_sticky),
    .issue_count    (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       op;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  typedef struct {
    logic [1:0]       alu_op;
    logic [3:0]       funct;
    logic [TAG_W-1:0] tag;
    logic [3:0]       exp_op;
    logic             exp_ill;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t m_q[$];
  ent_t m_last;
  logic m_sticky;
  int   m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the operation table.
  function automatic ent_t ref_dec(input logic [1:0] a, input logic [3:0] f, input logic [TAG_W-1:0] t);
    ent_t e;
    e.tag = t;
    e.op  = 4'hF;
    e.ill = 1'b1;
    if (a == 2'd0) begin e.op = 4'h2; e.ill = 1'b0; end
    else if (a == 2'd1) begin e.op = 4'h6; e.ill = 1'b0; end
    else if (a == 2'd2) begin
      if (f == 4'h0)      begin e.op = 4'h2; e.ill = 1'b0; end
      else if (f == 4'h8) begin e.op = 4'h6; e.ill = 1'b0; end
      else if (f == 4'h7) begin e.op = 4'h0; e.ill = 1'b0; end
      else if (f == 4'h6) begin e.op = 4'h1; e.ill = 1'b0; end
    end
    return e;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_last   = '{op: 4'h0, ill: 1'b0, tag: '0};
    m_sticky = 1'b0;
    m_cnt    = 0;
  endtask

  // Model the effect of one clock edge: FIFO of at most two ops, head presented.
  task automatic model_edge();
    bit   in_x;
    bit   out_x;
    ent_t e;
    in_x  = bus.in_valid && (m_q.size() < 2);
    out_x = (m_q.size() > 0) && bus.out_ready;
    e     = ref_dec(bus.in_alu_op, bus.in_funct, bus.in_tag);
    if (m_q.size() > 0) m_last = m_q[0];
    if (out_x) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (in_x && !flush && e.ill) m_sticky = 1'b1;
    else if (illegal_clr) m_sticky = 1'b0;
    if (flush) begin
      m_q.delete();
    end else begin
      if (out_x) void'(m_q.pop_front());
      if (in_x) m_q.push_back(e);
    end
    if (m_q.size() > 0) m_last = m_q[0];
  endtask

  task automatic check_all();
    chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    chk("in_ready", 32'(bus.in_ready), 32'(m_q.size() < 2));
    chk("out_operation", 32'(bus.out_operation), 32'(m_last.op));
    chk("out_tag", 32'(bus.out_tag), 32'(m_last.tag));
    chk("out_illegal", 32'(bus.out_illegal), 32'(m_last.ill));
    chk("illegal_sticky", 32'(illegal_sticky), 32'(m_sticky));
    chk("issue_count", 32'(issue_count), 32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [3:0] f, input logic [TAG_W-1:0] t);
    bus.in_valid  = v;
    bus.in_alu_op = a;
    bus.in_funct  = f;
    bus.in_tag    = t;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  vec_t       vecs[12];
  logic [3:0] got[$];
  logic [3:0] exp_seq[3];
  int         cnt_before;
  bit         acc;

  initial begin
    vecs[0]  = '{2'b00, 4'h0, 5'd1,  4'h2, 1'b0};
    vecs[1]  = '{2'b00, 4'h5, 5'd2,  4'h2, 1'b0};
    vecs[2]  = '{2'b01, 4'h0, 5'd3,  4'h6, 1'b0};
    vecs[3]  = '{2'b01, 4'hF, 5'd4,  4'h6, 1'b0};
    vecs[4]  = '{2'b10, 4'h0, 5'd5,  4'h2, 1'b0};
    vecs[5]  = '{2'b10, 4'h8, 5'd6,  4'h6, 1'b0};
    vecs[6]  = '{2'b10, 4'h7, 5'd7,  4'h0, 1'b0};
    vecs[7]  = '{2'b10, 4'h6, 5'd8,  4'h1, 1'b0};
    vecs[8]  = '{2'b10, 4'h5, 5'd9,  4'hF, 1'b1};
    vecs[9]  = '{2'b10, 4'hF, 5'd10, 4'hF, 1'b1};
    vecs[10] = '{2'b11, 4'h0, 5'd11, 4'hF, 1'b1};
    vecs[11] = '{2'b11, 4'h7, 5'd31, 4'hF, 1'b1};
    exp_seq[0] = 4'h2;
    exp_seq[1] = 4'h6;
    exp_seq[2] = 4'h1;

    rst_n = 1'b0;
    flush = 1'b0;
    illegal_clr = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 2'b00, 4'h0, '0);
    @(negedge clk);
    do_reset();
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_operation", 32'(bus.out_operation), 32'd0);

    // Single op through an empty stage.
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, 4'h7, 5'd3);
    step();
    chk("single out_valid", 32'(bus.out_valid), 32'd1);
    chk("single out_operation", 32'(bus.out_operation), 32'h0);
    chk("single out_tag", 32'(bus.out_tag), 32'd3);
    drive(1'b0, 2'b00, 4'h0, '0);
    step();
    chk("single issue_count", 32'(issue_count), 32'd1);

    // Decode table, back-to-back at full throughput.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].alu_op, vecs[i].funct, vecs[i].tag);
      step();
      chk("table out_valid", 32'(bus.out_valid), 32'd1);
      chk("table out_operation", 32'(bus.out_operation), 32'(vecs[i].exp_op));
      chk("table out_illegal", 32'(bus.out_illegal), 32'(vecs[i].exp_ill));
      chk("table out_tag", 32'(bus.out_tag), 32'(vecs[i].tag));
    end
    drive(1'b0, 2'b00, 4'h0, '0);
    step();

    // Back-pressure: three ops against a stalled execute stage.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 4'h3, 5'd20);
    step();
    chk("bp in_ready after 1st", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 2'b01, 4'h3, 5'd21);
    step();
    chk("bp in_ready after 2nd", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 2'b10, 4'h6, 5'd22);
    step();
    chk("bp 3rd held", 32'(bus.in_ready), 32'd0);
    chk("bp head op", 32'(bus.out_operation), 32'h2);
    bus.out_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid) got.push_back(bus.out_operation);
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) bus.in_valid = 1'b0;
    end
    chk("bp output count", 32'(got.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) chk("bp output order", 32'(got[k]), 32'(exp_seq[k]));
    end

    // Illegal op and sticky set/clear priority.
    drive(1'b1, 2'b10, 4'h5, 5'd12);
    step();
    chk("illegal op", 32'(bus.out_operation), 32'hF);
    chk("illegal flag", 32'(bus.out_illegal), 32'd1);
    chk("illegal sticky set", 32'(illegal_sticky), 32'd1);
    illegal_clr = 1'b1;
    step();
    chk("illegal sticky set wins", 32'(illegal_sticky), 32'd1);
    drive(1'b0, 2'b00, 4'h0, '0);
    step();
    chk("illegal sticky cleared", 32'(illegal_sticky), 32'd0);
    illegal_clr = 1'b0;
    step();

    // Flush while holding two ops, with a new op presented in the flush cycle.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 4'h0, 5'd13);
    step();
    drive(1'b1, 2'b01, 4'h0, 5'd14);
    step();
    chk("flush pre in_ready", 32'(bus.in_ready), 32'd0);
    cnt_before = m_cnt;
    drive(1'b1, 2'b10, 4'h8, 5'd15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush issue_count", 32'(issue_count), 32'(cnt_before));
    drive(1'b0, 2'b00, 4'h0, '0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush nothing out", 32'(bus.out_valid), 32'd0);
    end

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      drive(1'(($urandom % 4) != 0), 2'($urandom), 4'($urandom), TAG_W'($urandom));
      if ($urandom % 2 == 0) bus.in_funct = ($urandom % 2 == 0) ? 4'h6 : 4'h8;
      bus.out_ready = 1'(($urandom % 3) != 0);
      flush         = 1'(($urandom % 20) == 0);
      illegal_clr   = 1'(($urandom % 15) == 0);
      step();
    end
    flush = 1'b0;
    illegal_clr = 1'b0;
    drive(1'b0, 2'b00, 4'h0, '0);

    // Counter wrap: 17 transfers on a 4-bit counter.
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 2'b00, 4'h0, TAG_W'(k));
      step();
    end
    drive(1'b0, 2'b00, 4'h0, '0);
    step();
    chk("wrap issue_count", 32'(issue_count), 32'd1);

    // Asynchronous reset while in the skid state.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b10, 4'h5, 5'd17);
    step();
    drive(1'b1, 2'b01, 4'h0, 5'd18);
    step();
    drive(1'b0, 2'b00, 4'h0, '0);
    chk("arst pre in_ready", 32'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst out_operation", 32'(bus.out_operation), 32'd0);
    chk("arst out_tag", 32'(bus.out_tag), 32'd0);
    chk("arst out_illegal", 32'(bus.out_illegal), 32'd0);
    chk("arst sticky", 32'(illegal_sticky), 32'd0);
    chk("arst issue_count", 32'(issue_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
